// File: rtl/chk_pkg.sv
// Shared types and helpers for the RFC 1071 checksum engine.
package chk_pkg;

  typedef enum logic {
    CHK_GEN    = 1'b0,
    CHK_VERIFY = 1'b1
  } chk_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_RESULT = 2'd2
  } chk_state_e;

  localparam int unsigned BYTE_W = 8;
  // One beat of up to 8 bytes weighted as 0xFF00 each fits in 20 bits.
  localparam int unsigned SUM_W  = 20;

  // Bits needed to hold a popcount of n lanes.
  function automatic int unsigned lane_cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // 32 -> 16 ones'-complement fold; the second end-around add can never carry again.
  function automatic logic [15:0] ones_fold32(input logic [31:0] a);
    logic [16:0] f1;
    logic [16:0] f2;
    f1 = {1'b0, a[15:0]} + {1'b0, a[31:16]};
    f2 = {1'b0, f1[15:0]} + {16'h0000, f1[16]};
    return f2[15:0];
  endfunction

endpackage

// File: rtl/chk_lane_sum.sv
// Weighted sum of one beat: each kept byte lands high or low in the 16-bit
// word depending on its running byte parity, so odd boundaries carry across beats.
module chk_lane_sum
  import chk_pkg::*;
#(
  parameter int DATA_BYTES = 4
) (
  input  logic [8*DATA_BYTES-1:0] data_i,
  input  logic [DATA_BYTES-1:0]   keep_i,
  input  logic                    phase_i,
  output logic [SUM_W-1:0]        sum_o,
  output logic                    phase_o
);

  // Walk lanes in wire order, flipping parity after every kept byte.
  always_comb begin
    logic             p;
    logic [SUM_W-1:0] s;
    p = phase_i;
    s = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (keep_i[i]) begin
        s = s + (p ? {12'h000, data_i[8*i +: 8]} : {4'h0, data_i[8*i +: 8], 8'h00});
        p = ~p;
      end
    end
    sum_o   = s;
    phase_o = p;
  end

endmodule

// File: rtl/inet_checksum_engine.sv
// RFC 1071 ones'-complement checksum over byte-enabled beats with a
// registered valid/ready result. Used for both header generation and check.
module inet_checksum_engine
  import chk_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init,
  input  logic                    mode,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [8*DATA_BYTES-1:0] s_data,
  input  logic [DATA_BYTES-1:0]   s_keep,
  input  logic                    s_en,
  input  logic                    s_last,
  output logic                    r_valid,
  input  logic                    r_ready,
  output logic [15:0]             r_checksum,
  output logic                    r_ok,
  output logic [CNT_WIDTH-1:0]    r_byte_count,
  output logic                    r_overflow
);

  localparam int unsigned KW = lane_cnt_w(DATA_BYTES);

  chk_state_e           state_q;
  logic [31:0]          acc_q;
  logic                 phase_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 ovf_q;
  logic                 s_ready_q;
  logic                 r_valid_q;
  logic [15:0]          r_checksum_q;
  logic                 r_ok_q;
  logic [CNT_WIDTH-1:0] r_byte_count_q;
  logic                 r_overflow_q;

  logic [SUM_W-1:0]     lane_sum;
  logic                 lane_phase;

  logic [31:0]          acc_d;
  logic                 phase_d;
  logic [CNT_WIDTH-1:0] count_d;
  logic                 ovf_d;
  logic [15:0]          fold;

  chk_lane_sum #(.DATA_BYTES(DATA_BYTES)) u_lane (
    .data_i  (s_data),
    .keep_i  (s_keep),
    .phase_i (phase_q),
    .sum_o   (lane_sum),
    .phase_o (lane_phase)
  );

  // Next accumulator/phase/count if the current beat is accepted; the fold
  // includes this beat so the s_last edge can load the final result.
  always_comb begin
    logic [KW-1:0]      pop;
    logic [CNT_WIDTH:0] pop_ext;
    logic [CNT_WIDTH:0] cnt_sum;
    pop = '0;
    for (int i = 0; i < DATA_BYTES; i++) pop = pop + KW'(s_keep[i]);
    pop_ext = '0;
    pop_ext[KW-1:0] = pop;
    cnt_sum = {1'b0, count_q} + pop_ext;
    acc_d   = s_en ? acc_q + {{(32-SUM_W){1'b0}}, lane_sum} : acc_q;
    phase_d = s_en ? lane_phase : phase_q;
    count_d = !s_en ? count_q : (cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0]);
    ovf_d   = ovf_q | (s_en & cnt_sum[CNT_WIDTH]);
    fold    = ones_fold32(acc_d);
  end

  // Message FSM with registered handshake and result outputs. After a result
  // handshake s_ready stays low one extra cycle before the next message.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      acc_q          <= '0;
      phase_q        <= 1'b0;
      count_q        <= '0;
      ovf_q          <= 1'b0;
      s_ready_q      <= 1'b1;
      r_valid_q      <= 1'b0;
      r_checksum_q   <= '0;
      r_ok_q         <= 1'b0;
      r_byte_count_q <= '0;
      r_overflow_q   <= 1'b0;
    end else if (init) begin
      state_q        <= ST_IDLE;
      acc_q          <= '0;
      phase_q        <= 1'b0;
      count_q        <= '0;
      ovf_q          <= 1'b0;
      s_ready_q      <= 1'b1;
      r_valid_q      <= 1'b0;
      r_checksum_q   <= '0;
      r_ok_q         <= 1'b0;
      r_byte_count_q <= '0;
      r_overflow_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACCUM: begin
          if (!s_ready_q) begin
            s_ready_q <= 1'b1;
          end else if (s_valid) begin
            acc_q   <= acc_d;
            phase_q <= phase_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (s_last) begin
              state_q        <= ST_RESULT;
              s_ready_q      <= 1'b0;
              r_valid_q      <= 1'b1;
              r_checksum_q   <= ~fold;
              r_ok_q         <= (chk_mode_e'(mode) == CHK_VERIFY) && (fold == 16'hFFFF);
              r_byte_count_q <= count_d;
              r_overflow_q   <= ovf_d;
            end else begin
              state_q <= ST_ACCUM;
            end
          end
        end
        ST_RESULT: begin
          if (r_ready) begin
            state_q   <= ST_IDLE;
            r_valid_q <= 1'b0;
            acc_q     <= '0;
            phase_q   <= 1'b0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_ready      = s_ready_q;
  assign r_valid      = r_valid_q;
  assign r_checksum   = r_checksum_q;
  assign r_ok         = r_ok_q;
  assign r_byte_count = r_byte_count_q;
  assign r_overflow   = r_overflow_q;

endmodule

// File: tb/tb_inet_checksum_engine.sv
// Directed bench for inet_checksum_engine with DATA_BYTES = 4.
module tb_inet_checksum_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init = 1'b0;
  logic        mode = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic [3:0]  s_keep = '0;
  logic        s_en = 1'b0;
  logic        s_last = 1'b0;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic [15:0] r_checksum;
  logic        r_ok;
  logic [15:0] r_byte_count;
  logic        r_overflow;

  int tests = 0;
  int fails = 0;

  logic [7:0] hdr[$] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00,
                         8'h40, 8'h11, 8'h00, 8'h00, 8'hc0, 8'ha8, 8'h00, 8'h01,
                         8'hc0, 8'ha8, 8'h00, 8'hc7};

  inet_checksum_engine #(.DATA_BYTES(4), .CNT_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .init         (init),
    .mode         (mode),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_keep       (s_keep),
    .s_en         (s_en),
    .s_last       (s_last),
    .r_valid      (r_valid),
    .r_ready      (r_ready),
    .r_checksum   (r_checksum),
    .r_ok         (r_ok),
    .r_byte_count (r_byte_count),
    .r_overflow   (r_overflow)
  );

  always #5 clk = ~clk;

  // Keep must be contiguous from lane 0 on every accepted beat.
  always @(posedge clk) begin
    logic [3:0] kp1;
    kp1 = s_keep + 4'd1;
    if (s_valid && s_ready) assert ((kp1 & s_keep) == 4'd0);
  end

  task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic en,
                      input logic last, input logic md);
    int n;
    n = 0;
    @(negedge clk);
    s_valid = 1'b1; s_data = d; s_keep = k; s_en = en; s_last = last; mode = md;
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!s_ready) begin
      fails++;
      $display("FAIL beat_accept s_ready got %0b want 1", s_ready);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] b[$], input logic en, input logic last,
                          input logic md);
    int i;
    logic [31:0] d;
    logic [3:0]  k;
    i = 0;
    while (i < b.size()) begin
      d = '0;
      k = '0;
      for (int j = 0; j < 4; j++) begin
        if (i < b.size()) begin
          d[8*j +: 8] = b[i];
          k[j] = 1'b1;
          i++;
        end
      end
      beat(d, k, en, last && (i >= b.size()), md);
    end
  endtask

  task automatic wait_result(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!r_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!r_valid) begin
      fails++;
      $display("FAIL %s r_valid timeout got 0 want 1", nm);
    end
  endtask

  task automatic consume();
    @(negedge clk);
    r_ready = 1'b1;
    @(posedge clk);
    #1;
    r_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if (s_ready !== 1'b1 || r_valid !== 1'b0 || r_checksum !== 16'h0 || r_ok !== 1'b0 ||
        r_byte_count !== 16'h0 || r_overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs got rdy=%0b vld=%0b cks=%h ok=%0b cnt=%0d ovf=%0b want 1 0 0000 0 0 0",
               s_ready, r_valid, r_checksum, r_ok, r_byte_count, r_overflow);
    end
  endtask

  task automatic test_ipv4_gen();
    send_msg(hdr, 1'b1, 1'b1, 1'b0);
    wait_result("ipv4_gen");
    tests++;
    if (r_checksum !== 16'hB861 || r_byte_count !== 16'd20 || r_ok !== 1'b0) begin
      fails++;
      $display("FAIL ipv4_gen got cks=%h cnt=%0d ok=%0b want b861 20 0", r_checksum, r_byte_count, r_ok);
    end
    consume();
  endtask

  task automatic test_ipv4_verify();
    logic [7:0] q[$];
    q = hdr;
    q[10] = 8'hb8;
    q[11] = 8'h61;
    send_msg(q, 1'b1, 1'b1, 1'b1);
    wait_result("ipv4_verify");
    tests++;
    if (r_ok !== 1'b1 || r_checksum !== 16'h0000) begin
      fails++;
      $display("FAIL ipv4_verify got ok=%0b cks=%h want 1 0000", r_ok, r_checksum);
    end
    consume();
    q[0] = 8'h44;
    send_msg(q, 1'b1, 1'b1, 1'b1);
    wait_result("ipv4_bitflip");
    tests++;
    if (r_ok !== 1'b0 || r_checksum !== 16'h0100) begin
      fails++;
      $display("FAIL ipv4_bitflip got ok=%0b cks=%h want 0 0100", r_ok, r_checksum);
    end
    consume();
  endtask

  task automatic test_odd_length();
    beat(32'h00030201, 4'b0111, 1'b1, 1'b1, 1'b0);
    wait_result("odd_one_beat");
    tests++;
    if (r_checksum !== 16'hFBFD || r_byte_count !== 16'd3) begin
      fails++;
      $display("FAIL odd_one_beat got cks=%h cnt=%0d want fbfd 3", r_checksum, r_byte_count);
    end
    consume();
    beat(32'h000000_01, 4'b0001, 1'b1, 1'b0, 1'b0);
    beat(32'h0000_0302, 4'b0011, 1'b1, 1'b1, 1'b0);
    wait_result("odd_split");
    tests++;
    if (r_checksum !== 16'hFBFD || r_byte_count !== 16'd3) begin
      fails++;
      $display("FAIL odd_split got cks=%h cnt=%0d want fbfd 3", r_checksum, r_byte_count);
    end
    consume();
  endtask

  task automatic test_backpressure();
    beat(32'h00030201, 4'b0111, 1'b1, 1'b1, 1'b0);
    wait_result("bp");
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (s_ready !== 1'b0 || r_valid !== 1'b1 || r_checksum !== 16'hFBFD || r_byte_count !== 16'd3) begin
        fails++;
        $display("FAIL bp_hold cycle %0d got rdy=%0b vld=%0b cks=%h cnt=%0d want 0 1 fbfd 3",
                 c, s_ready, r_valid, r_checksum, r_byte_count);
      end
      @(negedge clk);
    end
    r_ready = 1'b1;
    @(posedge clk);
    #1;
    r_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (r_valid !== 1'b0 || s_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_after_hs got vld=%0b rdy=%0b want 0 0", r_valid, s_ready);
    end
    s_valid = 1'b1; s_data = '0; s_keep = 4'b0000; s_en = 1'b1; s_last = 1'b1; mode = 1'b0;
    @(negedge clk);
    tests++;
    if (s_ready !== 1'b1 || r_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_reassert got rdy=%0b vld=%0b want 1 0", s_ready, r_valid);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
    tests++;
    if (r_valid !== 1'b1 || r_checksum !== 16'hFFFF) begin
      fails++;
      $display("FAIL bp_next_msg got vld=%0b cks=%h want 1 ffff", r_valid, r_checksum);
    end
    consume();
  endtask

  task automatic test_init_abort();
    logic [7:0] q[$];
    q = hdr[0:7];
    send_msg(q, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    tests++;
    if (r_valid !== 1'b0 || s_ready !== 1'b1) begin
      fails++;
      $display("FAIL init_abort got vld=%0b rdy=%0b want 0 1", r_valid, s_ready);
    end
    send_msg(hdr, 1'b1, 1'b1, 1'b0);
    wait_result("init_after");
    tests++;
    if (r_checksum !== 16'hB861 || r_byte_count !== 16'd20) begin
      fails++;
      $display("FAIL init_after got cks=%h cnt=%0d want b861 20", r_checksum, r_byte_count);
    end
    consume();
  endtask

  task automatic test_rst_in_result();
    beat(32'h00030201, 4'b0111, 1'b1, 1'b1, 1'b0);
    wait_result("rst_result");
    #2 rst = 1'b1;
    #1;
    tests++;
    if (r_valid !== 1'b0 || s_ready !== 1'b1 || r_checksum !== 16'h0) begin
      fails++;
      $display("FAIL rst_async got vld=%0b rdy=%0b cks=%h want 0 1 0000", r_valid, s_ready, r_checksum);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_skip();
    logic [7:0] q[$];
    q = {};
    for (int i = 0; i < 14; i++) q.push_back(8'hA5 + 8'(i));
    send_msg(q, 1'b0, 1'b0, 1'b0);
    send_msg(hdr, 1'b1, 1'b1, 1'b0);
    wait_result("skip");
    tests++;
    if (r_checksum !== 16'hB861 || r_byte_count !== 16'd20) begin
      fails++;
      $display("FAIL skip got cks=%h cnt=%0d want b861 20", r_checksum, r_byte_count);
    end
    consume();
  endtask

  task automatic test_edge_lengths();
    beat(32'h0, 4'b0000, 1'b1, 1'b1, 1'b0);
    wait_result("zero_len");
    tests++;
    if (r_checksum !== 16'hFFFF || r_byte_count !== 16'd0 || r_overflow !== 1'b0) begin
      fails++;
      $display("FAIL zero_len got cks=%h cnt=%0d ovf=%0b want ffff 0 0", r_checksum, r_byte_count, r_overflow);
    end
    consume();
    beat(32'h00030201, 4'b0111, 1'b1, 1'b0, 1'b0);
    beat(32'hDEADBEEF, 4'b1111, 1'b0, 1'b1, 1'b0);
    wait_result("last_unsummed");
    tests++;
    if (r_checksum !== 16'hFBFD || r_byte_count !== 16'd3) begin
      fails++;
      $display("FAIL last_unsummed got cks=%h cnt=%0d want fbfd 3", r_checksum, r_byte_count);
    end
    consume();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17500; i++) beat(32'h0, 4'b1111, 1'b1, i == 17499, 1'b0);
    wait_result("overflow");
    tests++;
    if (r_overflow !== 1'b1 || r_byte_count !== 16'hFFFF || r_checksum !== 16'hFFFF) begin
      fails++;
      $display("FAIL overflow got ovf=%0b cnt=%h cks=%h want 1 ffff ffff", r_overflow, r_byte_count, r_checksum);
    end
    consume();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_ipv4_gen();
    test_ipv4_verify();
    test_odd_length();
    test_backpressure();
    test_init_abort();
    test_rst_in_result();
    test_skip();
    test_edge_lengths();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inet_checksum_engine.md
Name: inet_checksum_engine

Overview:
- Parametrised RFC 1071 16-bit ones'-complement checksum engine that accepts DATA_BYTES bytes per beat.
- Input beats carry byte enables. Bytes are packed lane 0 first and may form an odd-length total.
- A registered result is presented through a valid/ready handshake.
- Sits after the Rx byte/word deserialiser for IPv4/UDP header checking, and in the Tx path for header checksum generation.

Parameters:
- DATA_BYTES, 4, bytes per input beat. Legal values are 1, 2, 4, 8.
- CNT_WIDTH, 16, width of the accepted-byte counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- init  in  1  clear accumulator, phase, counter and pending result. Returns to IDLE.
- mode  in  1  0 = generate, 1 = verify.
- s_valid  in  1  input beat valid.
- s_ready  out  1  engine can accept a beat.
- s_data  in  8*DATA_BYTES  beat data. Lane i is s_data[8i+7:8i], and lane 0 is the earliest byte on the wire.
- s_keep  in  DATA_BYTES  byte enables. Must be contiguous from lane 0. A zero keep is legal and contributes nothing.
- s_en  in  1  include this beat in the sum. When 0 the beat is consumed but ignored.
- s_last  in  1  final beat of the message.
- r_valid  out  1  result available.
- r_ready  in  1  result consumed.
- r_checksum  out  16  complement of the folded sum.
- r_ok  out  1  verify result: 1 when the folded sum equals 16'hFFFF. Forced to 0 in generate mode.
- r_byte_count  out  CNT_WIDTH  number of summed bytes.
- r_overflow  out  1  set if the byte counter saturated.

Behaviour:
- Reset and init state: every output is 0 except s_ready, which is 1. Internal state is acc = 0, phase = 0, count = 0, state = IDLE.
- States: IDLE, ACCUM, RESULT.
  - IDLE -> ACCUM on the first accepted beat without s_last.
  - IDLE or ACCUM -> RESULT on an accepted beat with s_last.
  - RESULT -> IDLE on r_valid && r_ready.
- Accept rule: a beat is accepted when s_valid && s_ready.
  - s_ready = 1 in IDLE and ACCUM, and 0 in RESULT.
- Lane weighting: for a summed beat, lane i with keep = 1 has position parity p = phase XOR (popcount of kept lanes below i) mod 2.
  - p = 0: the byte contributes {byte, 8'h00}.
  - p = 1: the byte contributes {8'h00, byte}.
- Per-beat bookkeeping:
  - phase toggles by the popcount of s_keep, mod 2.
  - count adds popcount(s_keep) and saturates at all ones; saturation sets the overflow flag.
  - Beats with s_en = 0 change neither acc, phase nor count.
- Accumulator width and fold:
  - acc is 32 bits. Lane sums are added without intermediate folding; the maximum 65535-byte message cannot overflow 32 bits.
  - The fold is done in the result cycle: f1 = acc[15:0] + acc[31:16], then f2 = f1[15:0] + f1[16].
- Odd length: a trailing high byte is implicitly zero-padded by the weighting rule. No extra beat is required.
- Latency: the result registers are loaded on the clock edge that accepts the s_last beat. That beat's lanes are included. r_valid rises the following cycle.
- Result outputs:
  - r_checksum = ~f2.
  - r_ok = mode && (f2 == 16'hFFFF).
  - mode is sampled on the s_last beat.
- Result hold: all r_* outputs stay stable while r_valid && !r_ready.
- Handshake completion: on r_valid && r_ready, r_valid drops next cycle, and acc, phase and count are cleared.
  - No back-to-back beat is accepted in that cycle; s_ready reasserts the cycle after.
- Simultaneous events:
  - init has priority over everything, including an accepting beat and a result handshake. Any pending result is discarded.
  - rst mid-message aborts the message with no result.
- A beat with s_last and s_en = 0 still terminates the message. The result reflects only earlier summed beats.
- A zero-length message (s_last on the first beat, no summed bytes) gives r_checksum = 16'hFFFF and r_byte_count = 0.
- Illegal s_keep (non-contiguous): behaviour is undefined. The verification bench asserts this never occurs.

Decomposition:
- Package chk_pkg holds:
  - the mode enum CHK_GEN / CHK_VERIFY;
  - the state enum;
  - the function ones_fold32 (32 -> 16 with end-around carry, applied twice);
  - localparam lane-count helpers.
- One sub-module, chk_lane_sum: a combinational weighted sum of one beat.
  - Inputs: data, keep, phase.
  - Outputs: 20-bit beat sum and next phase.
  - Kept separate so it can be unit-tested per DATA_BYTES.

Test Plan:
- IPv4 header, 20 bytes, DATA_BYTES = 4, generate: 45000073 00004000 40110000 c0a80001 c0a800c7 with the checksum field zeroed -> r_checksum = 16'hB861, r_byte_count = 20.
- Same header with B861 inserted at bytes 10-11, verify mode -> r_ok = 1 and r_checksum = 16'h0000. Flipping any single bit -> r_ok = 0.
- Odd length: bytes 01 02 03 as one beat, keep = 4'b0111 -> sum 0402, r_checksum = 16'hFBFD.
  - Repeat as beats {01} then {02 03} to check the phase carry across beats; the result must be identical.
- Backpressure: hold r_ready = 0 for 5 cycles after the result -> s_ready = 0 and r_* stable.
  - Then pulse r_ready; the next message is accepted 2 cycles after the handshake edge.
- Abort paths:
  - init asserted mid-message -> no r_valid; the following message's sum is unaffected.
  - rst asserted in RESULT -> r_valid = 0 asynchronously.
- Skip and edge cases:
  - 14 bytes with s_en = 0 followed by the 20-byte header -> same B861 result.
  - Zero-length message -> r_checksum = 16'hFFFF.
  - 70000 bytes of 00 -> r_overflow = 1.
